// File: rtl/irq_ctrl.sv
// irq_ctrl: edge-capturing interrupt controller with per-source enable,
// global enable, and a claim/complete handshake so the core services one
// interrupt at a time. Bus slave with REQ/CE/WE/RE in and GNT/RDATA out.
module irq_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_CE,
    input  logic             i_WE,
    input  logic             i_RE,
    input  logic [31:0]      i_ADDR,
    input  logic [31:0]      i_WDATA,
    input  logic             i_REQ,
    input  logic [N_SRC-1:0] i_SRC,
    output logic [31:0]      o_RDATA,
    output logic             o_GNT,
    output logic             o_IRQ
);

    localparam logic [31:0] ADDR_PENDING  = 32'h00;
    localparam logic [31:0] ADDR_ENABLE   = 32'h04;
    localparam logic [31:0] ADDR_CLAIM    = 32'h08;
    localparam logic [31:0] ADDR_COMPLETE = 32'h0C;
    localparam logic [31:0] ADDR_CTRL     = 32'h10;

    logic [N_SRC-1:0] r_srcQ;
    logic             r_armed;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_enable;
    logic             r_gen;
    logic             r_busy;
    logic [4:0]       r_claimedId;
    logic             r_gnt;
    logic [31:0]      r_rdata;
    logic             r_irq;

    logic [N_SRC-1:0] w_rise;
    logic             w_wrAcc;
    logic             w_rdAcc;
    logic [N_SRC-1:0] w_cand;
    logic             w_candHit;
    logic [4:0]       w_candIdx;
    logic [4:0]       w_claimId;
    logic             w_claimFire;
    logic [N_SRC-1:0] w_claimMask;
    logic [N_SRC-1:0] w_w1cMask;
    logic             w_completeOk;
    logic [31:0]      w_rdMux;

    // r_armed holds off edge detection for the first cycle after reset, so a
    // line already high when reset drops is sampled into r_srcQ, not captured.
    assign w_rise  = r_armed ? (i_SRC & ~r_srcQ) : '0;
    assign w_wrAcc = i_WE & i_REQ & i_CE;
    assign w_rdAcc = i_RE & i_REQ & i_CE;
    assign w_cand  = r_pending & r_enable;

    // Lowest-index pending-and-enabled source wins; scanning downward lets the
    // lowest hit overwrite any higher one.
    always_comb begin
        w_candHit = 1'b0;
        w_candIdx = 5'd0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (w_cand[k]) begin
                w_candHit = 1'b1;
                w_candIdx = 5'(k);
            end
        end
    end

    assign w_claimId    = (w_candHit && !r_busy) ? (w_candIdx + 5'd1) : 5'd0;
    assign w_claimFire  = w_rdAcc && (i_ADDR == ADDR_CLAIM) && (w_claimId != 5'd0);
    assign w_claimMask  = w_claimFire ? (N_SRC'(1) << w_candIdx) : '0;
    assign w_w1cMask    = (w_wrAcc && (i_ADDR == ADDR_PENDING)) ? i_WDATA[N_SRC-1:0] : '0;
    assign w_completeOk = w_wrAcc && (i_ADDR == ADDR_COMPLETE) && r_busy &&
                          (i_WDATA == 32'(r_claimedId));

    // Read mux over current-cycle register values; unmapped offsets read 0.
    always_comb begin
        w_rdMux = 32'd0;
        case (i_ADDR)
            ADDR_PENDING:  w_rdMux = 32'(r_pending);
            ADDR_ENABLE:   w_rdMux = 32'(r_enable);
            ADDR_CLAIM:    w_rdMux = 32'(w_claimId);
            ADDR_COMPLETE: w_rdMux = 32'(r_claimedId);
            ADDR_CTRL:     w_rdMux = {31'd0, r_gen};
            default:       w_rdMux = 32'd0;
        endcase
    end

    // Edge capture into pending; a new rise wins over W1C or claim clears.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_srcQ    <= '0;
            r_armed   <= 1'b0;
            r_pending <= '0;
        end else begin
            r_srcQ    <= i_SRC;
            r_armed   <= 1'b1;
            r_pending <= (r_pending & ~w_w1cMask & ~w_claimMask) | w_rise;
        end
    end

    // Software-visible control state: enable mask, global enable, claim tracking.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_enable    <= '0;
            r_gen       <= 1'b0;
            r_busy      <= 1'b0;
            r_claimedId <= 5'd0;
        end else begin
            if (w_wrAcc && (i_ADDR == ADDR_ENABLE)) begin
                r_enable <= i_WDATA[N_SRC-1:0];
            end
            if (w_wrAcc && (i_ADDR == ADDR_CTRL)) begin
                r_gen <= i_WDATA[0];
            end
            if (w_claimFire) begin
                r_busy      <= 1'b1;
                r_claimedId <= w_claimId;
            end else if (w_completeOk) begin
                r_busy      <= 1'b0;
                r_claimedId <= 5'd0;
            end
        end
    end

    // Bus response: grant one cycle after request, read data zero unless a read was accepted.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_gnt   <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_gnt   <= i_REQ & i_CE;
            r_rdata <= w_rdAcc ? w_rdMux : 32'd0;
        end
    end

    // Registered interrupt request, suppressed while an interrupt is in service.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_gen & ~r_busy & (|w_cand);
        end
    end

    assign o_GNT   = r_gnt;
    assign o_RDATA = r_rdata;
    assign o_IRQ   = r_irq;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed test-plan sequences followed by a randomized phase.
// The driver steps a register-level reference model and queues the expected
// outputs; an independent monitor pops and compares on every falling edge.
module tb_irq_ctrl;

   localparam int N = 8;

   logic          clk;
   logic          rst;
   logic          ce;
   logic          we;
   logic          re;
   logic          req;
   logic [31:0]   addr;
   logic [31:0]   wdata;
   logic [N-1:0]  src;
   logic [31:0]   rdata;
   logic          gnt;
   logic          irq;

   irq_ctrl #(.N_SRC(N)) dut (
      .i_CLK   (clk),
      .i_RST   (rst),
      .i_CE    (ce),
      .i_WE    (we),
      .i_RE    (re),
      .i_ADDR  (addr),
      .i_WDATA (wdata),
      .i_REQ   (req),
      .i_SRC   (src),
      .o_RDATA (rdata),
      .o_GNT   (gnt),
      .o_IRQ   (irq)
   );

   typedef struct {
      logic        gnt;
      logic [31:0] rdata;
      logic        irq;
   } exp_t;

   exp_t expQ[$];

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [N-1:0] mPend;
   logic [N-1:0] mEn;
   bit           mGen;
   bit           mBusy;
   int           mCid;
   logic [N-1:0] mPrev;
   bit           mSampled;
   logic [N-1:0] srcVal;

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void modelReset();
      mPend    = '0;
      mEn      = '0;
      mGen     = 0;
      mBusy    = 0;
      mCid     = 0;
      mPrev    = '0;
      mSampled = 0;
   endfunction

   // Monitor: compare every queued cycle expectation against the DUT outputs
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("gnt",   32'(gnt),  32'(e.gnt));
            checkOutput("irq",   32'(irq),  32'(e.irq));
            checkOutput("rdata", rdata,     e.rdata);
         end
      end
   end

   // One bus cycle: drive inputs, advance the model, queue the expectation
   task automatic applyStimulus(input bit q, input bit c, input bit w, input bit r,
                                input logic [31:0] a, input logic [31:0] d);
      exp_t         e;
      bit           acc;
      logic [N-1:0] rise;
      logic [N-1:0] cand;
      logic [N-1:0] np;
      int           id;
      logic [31:0]  rv;
      req   = q;
      ce    = c;
      we    = w;
      re    = r;
      addr  = a;
      wdata = d;
      src   = srcVal;

      acc  = q && c;
      rise = mSampled ? (srcVal & ~mPrev) : '0;
      cand = mPend & mEn;
      id   = 0;
      if (!mBusy) begin
         for (int k = 0; k < N; k++) begin
            if (cand[k] && id == 0) id = k + 1;
         end
      end
      rv = 32'd0;
      if (acc && r) begin
         case (a)
            32'h00:  rv = 32'(mPend);
            32'h04:  rv = 32'(mEn);
            32'h08:  rv = 32'(id);
            32'h0C:  rv = 32'(mCid);
            32'h10:  rv = 32'(mGen);
            default: rv = 32'd0;
         endcase
      end
      e.gnt   = acc;
      e.rdata = rv;
      e.irq   = mGen && !mBusy && (cand != '0);

      np = mPend;
      if (acc && w && a == 32'h00) np = np & ~d[N-1:0];
      if (acc && w && a == 32'h0C && mBusy && d == 32'(mCid)) begin
         mBusy = 0;
         mCid  = 0;
      end
      if (acc && r && a == 32'h08 && id != 0) begin
         np[id-1] = 1'b0;
         mBusy    = 1;
         mCid     = id;
      end
      np = np | rise;
      if (acc && w && a == 32'h04) mEn  = d[N-1:0];
      if (acc && w && a == 32'h10) mGen = d[0];
      mPend    = np;
      mPrev    = srcVal;
      mSampled = 1;

      @(posedge clk);
      expQ.push_back(e);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      applyStimulus(1, 1, 1, 0, a, d);
   endtask

   task automatic rd(input logic [31:0] a);
      applyStimulus(1, 1, 0, 1, a, 32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
   endtask

   task automatic pulse(input logic [N-1:0] m);
      srcVal = m;
      idle(1);
      srcVal = '0;
   endtask

   // Reset with the current srcVal held on the lines; outputs must clear at once
   task automatic doReset();
      @(negedge clk);
      #1;
      rst = 1'b1;
      req = 0; ce = 0; we = 0; re = 0;
      src = srcVal;
      #1;
      checkOutput("rst_irq",   32'(irq), 32'd0);
      checkOutput("rst_gnt",   32'(gnt), 32'd0);
      checkOutput("rst_rdata", rdata,    32'd0);
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 0; ce = 0; we = 0; re = 0;
      addr = '0; wdata = '0; srcVal = '0; src = '0;
      modelReset();
      #2;
      checkOutput("rst_irq",   32'(irq), 32'd0);
      checkOutput("rst_gnt",   32'(gnt), 32'd0);
      checkOutput("rst_rdata", rdata,    32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset and idle
      rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h10); idle(1);

      // Basic timer interrupt
      wr(32'h04, 32'h01); wr(32'h10, 32'h1);
      pulse(8'h01); idle(1);
      rd(32'h00); idle(1);
      rd(32'h08); idle(1); rd(32'h00);
      wr(32'h0C, 32'd1); rd(32'h08); idle(1);

      // Priority
      wr(32'h04, 32'hFF);
      pulse(8'h24); idle(1);
      rd(32'h08); wr(32'h0C, 32'd3); idle(1);
      rd(32'h08); wr(32'h0C, 32'd6); idle(2);

      // Masking and W1C
      wr(32'h04, 32'h00);
      pulse(8'h02); idle(2);
      rd(32'h00);
      wr(32'h04, 32'h02); idle(2);
      wr(32'h00, 32'h02); idle(1);
      rd(32'h00); idle(1);

      // Collision
      wr(32'h04, 32'h01);
      srcVal = 8'h01;
      wr(32'h00, 32'h01);
      srcVal = 8'h00;
      rd(32'h00);
      rd(32'h08);
      wr(32'h0C, 32'd4);
      rd(32'h08); rd(32'h0C);
      wr(32'h0C, 32'd1); idle(1);

      // Reset mid-service with line held high
      pulse(8'h01); idle(1);
      rd(32'h08);
      srcVal = 8'h01;
      doReset();
      idle(3);
      rd(32'h00);
      srcVal = 8'h00; idle(1);
      srcVal = 8'h01; idle(1);
      rd(32'h00);
      srcVal = 8'h00;

      // Randomized phase
      for (int i = 0; i < 400; i++) begin
         int op;
         logic [31:0] a;
         logic [31:0] d;
         bit q, c;
         op = int'($urandom_range(0, 5));
         case ($urandom_range(0, 5))
            0: a = 32'h00;
            1: a = 32'h04;
            2: a = 32'h08;
            3: a = 32'h0C;
            4: a = 32'h10;
            default: a = 32'h14;
         endcase
         d = ($urandom_range(0, 1) == 1) ? 32'(mCid) : 32'($urandom_range(0, 255));
         q = ($urandom_range(0, 7) != 0);
         c = ($urandom_range(0, 7) != 0);
         srcVal = N'($urandom) & N'($urandom) & N'($urandom);
         case (op)
            0, 1: applyStimulus(q, c, 0, 1, a, 32'd0);
            2, 3: applyStimulus(q, c, 1, 0, a, d);
            4:    applyStimulus(q, c, 1, 1, a, d);
            default: idle(1);
         endcase
      end
      srcVal = '0;
      idle(2);

      @(negedge clk);
      #1;
      checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Memory-mapped interrupt controller directly downstream of the timer and other peripherals.
- Captures rising edges on up to N_SRC interrupt lines into pending bits, masks them per source, and drives a single o_IRQ to the core.
- Provides claim/complete registers so that one interrupt is serviced at a time.
- Uses the same slave bus handshake as the other peripherals: REQ/CE/WE/RE in, GNT/RDATA out.

Parameters:
- N_SRC, 8, number of interrupt sources (1..31); source k has ID k+1.

Ports:
- i_CLK, input, 1, system clock (rising edge).
- i_RST, input, 1, asynchronous reset, active-high.
- i_CE, input, 1, chip enable (address decode hit).
- i_WE, input, 1, write strobe.
- i_RE, input, 1, read strobe.
- i_ADDR, input, 32, byte offset within the block.
- i_WDATA, input, 32, write data.
- i_REQ, input, 1, bus request.
- i_SRC, input, N_SRC, interrupt lines; bit 0 is the timer. Pulse or level accepted.
- o_RDATA, output, 32, read data, valid in the cycle o_GNT is high.
- o_GNT, output, 1, grant, one cycle after an accepted request.
- o_IRQ, output, 1, interrupt request to the core.

Behaviour:
- Reset is asynchronous, active-high. While i_RST is high:
  - src_q, pending, enable, gen, busy, claimed_id, gnt, rdata and irq are all 0.
  - o_IRQ=0, o_GNT=0, o_RDATA=0.
- Edge capture:
  - src_q <= i_SRC every cycle.
  - rise = i_SRC & ~src_q.
  - pending[k] sets on rise[k]. This happens regardless of enable/gen; masking applies only at the output.
- Bus access:
  - A write is accepted when i_WE&i_REQ&i_CE; a read when i_RE&i_REQ&i_CE.
  - gnt <= i_REQ&i_CE, giving 1-cycle latency.
  - rdata is registered and is 0 in any cycle without an accepted read.
- Register map (unlisted addresses read 0, writes ignored):
  - 0x00 PENDING: read returns zero-extended pending. Write-1-to-clear (W1C).
  - 0x04 ENABLE: R/W, bits [N_SRC-1:0]; upper bits read 0.
  - 0x08 CLAIM (read only):
    - Returns the ID of the lowest-index source with pending&enable set, or 0 if none, or if busy=1.
    - A nonzero claim, in the same accepted-read cycle: clears that pending bit, sets busy=1, and sets claimed_id=ID.
  - 0x0C COMPLETE:
    - A write with i_WDATA==claimed_id while busy clears busy and claimed_id.
    - A mismatched write is ignored.
    - Read returns claimed_id.
  - 0x10 CTRL: bit0=gen (global enable), R/W.
- Interrupt output:
  - irq <= gen & ~busy & |(pending & enable), registered.
  - o_IRQ = irq, so it drops one cycle after a claim read is accepted.
- Simultaneous events:
  - A set by rise wins over a W1C clear or claim clear of the same bit in the same cycle; pending stays 1.
  - A claim read and an edge on a different source in the same cycle: both take effect.
- Priority is a combinational lowest-index search, evaluated on current-cycle register values.
- Disabling a source or gen does not clear pending; re-enabling re-raises o_IRQ.
- Reset asserted mid-operation clears all state immediately; edges present on i_SRC at deassertion are captured only after src_q has sampled them. A line held high through reset therefore produces no interrupt.

Test Plan:
- Reset and idle:
  - Assert i_RST with i_SRC=0, then release.
  - Read 0x00, 0x04, 0x08, 0x10 -> all return 0, o_IRQ=0, and o_GNT pulses 1 cycle after each request.
- Basic timer interrupt:
  - Write ENABLE=0x01 and CTRL=1, then pulse i_SRC[0] for 1 cycle.
  - -> PENDING reads 0x01 and o_IRQ=1.
  - CLAIM read returns 1; the next cycle o_IRQ=0 and PENDING=0.
  - COMPLETE write of 1 -> busy clears; a subsequent CLAIM read returns 0.
- Priority:
  - ENABLE=0xFF, gen=1, pulse i_SRC[5] and i_SRC[2] together.
  - CLAIM -> 3. Complete 3.
  - CLAIM -> 6. Complete 6 -> o_IRQ=0.
- Masking and W1C:
  - ENABLE=0, pulse i_SRC[1] -> PENDING=0x02, o_IRQ stays 0.
  - Write ENABLE=0x02 -> o_IRQ=1.
  - Write PENDING=0x02 -> o_IRQ=0, PENDING=0.
- Collision:
  - Write PENDING=0x01 in the same cycle as a rise on i_SRC[0] -> PENDING remains 0x01.
  - Mismatched COMPLETE write of 4 while claimed_id=1 -> busy stays 1, CLAIM read returns 0.
- Reset mid-service:
  - Claim ID 1, then assert i_RST while holding i_SRC[0]=1, then release.
  - -> busy=0, pending=0, o_IRQ=0, and no new pending bit until i_SRC[0] falls and rises again.
